// File: rtl/hv_dac_sequencer.sv
// Four-chip serial DAC sequencer: per-chip setpoint queue, round-robin framing,
// SPI-style serial shifting and an LDAC load pulse (automatic or on request).
module hv_dac_sequencer #(
   parameter int SCLK_DIV = 4,
   parameter int LDAC_W   = 8
) (
   input  logic        dtc_clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  wr_chip,
   input  logic [23:0] wr_word,
   input  logic        auto_ldac,
   input  logic        ldac_req,
   output logic [3:0]  pending,
   output logic        busy,
   output logic        frame_done,
   output logic        hv_dac_sclk,
   output logic        hv_dac_din,
   output logic [3:0]  hv_dac_sync_b,
   output logic        hv_dac_load_b
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_LOAD} state_t;

   state_t            r_state, w_state_n;
   logic [15:0]       r_cnt, w_cnt_n;
   logic [4:0]        r_bit, w_bit_n;
   logic              r_hi, w_hi_n;
   logic [23:0]       r_shreg, w_shreg_n;
   logic [3:0][23:0]  r_word;
   logic [3:0]        r_pending;
   logic [1:0]        r_last;
   logic              r_dirty, r_ldac;
   logic              r_sclk, r_din, r_load_b, r_busy, r_fd;
   logic [3:0]        r_sync_b, w_sync_n;
   logic              w_rr_hit, w_grant, w_fend, w_ldac_take, w_load_end;
   logic [1:0]        w_rr_idx, w_gnt_n;

   // Round-robin search starting one past the last granted chip.
   always_comb begin
      w_rr_hit = 1'b0;
      w_rr_idx = r_last;
      for (int k = 1; k <= 4; k++) begin
         if (!w_rr_hit && r_pending[r_last + 2'(k)]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = r_last + 2'(k);
         end
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt + 16'd1;
      w_bit_n     = r_bit;
      w_hi_n      = r_hi;
      w_shreg_n   = r_shreg;
      w_grant     = 1'b0;
      w_fend      = 1'b0;
      w_ldac_take = 1'b0;
      w_load_end  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_n = '0;
            if (r_ldac) begin
               w_state_n   = S_LOAD;
               w_ldac_take = 1'b1;
            end else if (w_rr_hit) begin
               w_state_n = S_SETUP;
               w_grant   = 1'b1;
            end
         end
         S_SETUP: if (r_cnt == 16'(SCLK_DIV - 1)) begin
            w_state_n = S_SHIFT;
            w_cnt_n   = '0;
            w_hi_n    = 1'b0;
            w_bit_n   = 5'd23;
         end
         S_SHIFT: if (r_cnt == 16'(SCLK_DIV - 1)) begin
            w_cnt_n = '0;
            if (!r_hi) begin
               // Rising sclk: advance data so it is stable across the next fall.
               w_hi_n    = 1'b1;
               w_shreg_n = {r_shreg[22:0], 1'b0};
            end else begin
               w_hi_n = 1'b0;
               if (r_bit == 5'd0) begin
                  w_state_n = S_GAP;
                  w_fend    = 1'b1;
               end else begin
                  w_bit_n = r_bit - 5'd1;
               end
            end
         end
         S_GAP: if (r_cnt == 16'(SCLK_DIV - 1)) begin
            w_cnt_n = '0;
            if (w_rr_hit) begin
               w_state_n = S_SETUP;
               w_grant   = 1'b1;
            end else if (auto_ldac && r_dirty) begin
               w_state_n = S_LOAD;
            end else begin
               w_state_n = S_IDLE;
            end
         end
         S_LOAD: if (r_cnt == 16'(LDAC_W - 1)) begin
            w_state_n  = S_IDLE;
            w_cnt_n    = '0;
            w_load_end = 1'b1;
         end
         default: w_state_n = S_IDLE;
      endcase
      if (w_grant) w_shreg_n = r_word[w_rr_idx];
   end

   // Output values are decoded from the next state so every pin is a flop.
   always_comb begin
      w_gnt_n  = w_grant ? w_rr_idx : r_last;
      w_sync_n = 4'hF;
      if (w_state_n == S_SETUP || w_state_n == S_SHIFT) w_sync_n[w_gnt_n] = 1'b0;
   end

   always_ff @(posedge dtc_clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_hi      <= 1'b1;
         r_shreg   <= '0;
         r_word    <= '0;
         r_pending <= '0;
         r_last    <= 2'd3;
         r_dirty   <= 1'b0;
         r_ldac    <= 1'b0;
         r_sclk    <= 1'b1;
         r_din     <= 1'b0;
         r_sync_b  <= 4'hF;
         r_load_b  <= 1'b1;
         r_busy    <= 1'b0;
         r_fd      <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_hi    <= w_hi_n;
         r_shreg <= w_shreg_n;
         if (w_grant) r_last <= w_rr_idx;
         // A same-cycle write to the granted chip re-arms it for another frame.
         for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_chip == 2'(i)) begin
               r_pending[i] <= 1'b1;
               r_word[i]    <= wr_word;
            end else if (w_grant && w_rr_idx == 2'(i)) begin
               r_pending[i] <= 1'b0;
            end
         end
         if (w_fend)          r_dirty <= 1'b1;
         else if (w_load_end) r_dirty <= 1'b0;
         if (ldac_req)         r_ldac <= 1'b1;
         else if (w_ldac_take) r_ldac <= 1'b0;
         r_sclk   <= !(w_state_n == S_SHIFT && !w_hi_n);
         r_din    <= (w_state_n == S_SETUP || w_state_n == S_SHIFT) ? w_shreg_n[23] : 1'b0;
         r_sync_b <= w_sync_n;
         r_load_b <= (w_state_n != S_LOAD);
         r_busy   <= (w_state_n != S_IDLE);
         r_fd     <= w_fend;
      end
   end

   assign pending       = r_pending;
   assign busy          = r_busy;
   assign frame_done    = r_fd;
   assign hv_dac_sclk   = r_sclk;
   assign hv_dac_din    = r_din;
   assign hv_dac_sync_b = r_sync_b;
   assign hv_dac_load_b = r_load_b;

endmodule

// File: tb/tb_hv_dac_sequencer.sv
// Directed bench for hv_dac_sequencer: a pin monitor decodes frames and load
// pulses, and each scenario task checks them against hand-computed values.
module tb_hv_dac_sequencer;

   logic        dtc_clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_chip = '0;
   logic [23:0] wr_word = '0;
   logic        auto_ldac = 1'b0;
   logic        ldac_req = 1'b0;
   logic [3:0]  pending;
   logic        busy, frame_done, hv_dac_sclk, hv_dac_din, hv_dac_load_b;
   logic [3:0]  hv_dac_sync_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   hv_dac_sequencer #(.SCLK_DIV(4), .LDAC_W(8)) dut (
      .dtc_clk(dtc_clk), .rst(rst), .wr_en(wr_en), .wr_chip(wr_chip),
      .wr_word(wr_word), .auto_ldac(auto_ldac), .ldac_req(ldac_req),
      .pending(pending), .busy(busy), .frame_done(frame_done),
      .hv_dac_sclk(hv_dac_sclk), .hv_dac_din(hv_dac_din),
      .hv_dac_sync_b(hv_dac_sync_b), .hv_dac_load_b(hv_dac_load_b)
   );

   always #5 dtc_clk = ~dtc_clk;

   initial forever begin
      @(posedge dtc_clk);
      cyc++;
   end

   // Pin monitor: frames, sampled data bits on sclk falls, load pulses.
   int          q_chip[$], q_bits[$], q_len[$], q_tfall[$], q_tlfall[$], q_llen[$];
   logic [23:0] q_word[$];
   int          fd_cnt = 0, viol = 0;

   initial begin
      logic        m_sclk_p, m_load_p;
      logic [3:0]  m_sync_p;
      logic [23:0] m_sh;
      int          m_bits, m_len, m_chip, m_tfall, l_len;
      m_sclk_p = 1'b1; m_load_p = 1'b1; m_sync_p = 4'hF;
      m_sh = '0; m_bits = 0; m_len = 0; m_chip = 0; m_tfall = 0; l_len = 0;
      forever begin
         @(negedge dtc_clk);
         if (hv_dac_sync_b != 4'hF) begin
            if (m_sync_p == 4'hF) begin
               m_bits = 0; m_len = 0; m_sh = '0; m_tfall = cyc;
               for (int k = 0; k < 4; k++) if (!hv_dac_sync_b[k]) m_chip = k;
            end
            m_len++;
            if (m_sclk_p && !hv_dac_sclk) begin
               m_sh = {m_sh[22:0], hv_dac_din};
               m_bits++;
            end
         end else if (m_sync_p != 4'hF) begin
            q_chip.push_back(m_chip); q_word.push_back(m_sh); q_bits.push_back(m_bits);
            q_len.push_back(m_len); q_tfall.push_back(m_tfall);
         end
         if (!hv_dac_load_b) begin
            if (m_load_p) begin
               l_len = 0;
               q_tlfall.push_back(cyc);
            end
            l_len++;
         end else if (!m_load_p) begin
            q_llen.push_back(l_len);
         end
         if ($countones(~hv_dac_sync_b) > 1 || (hv_dac_sync_b != 4'hF && !hv_dac_load_b)) viol++;
         if (frame_done) fd_cnt++;
         m_sclk_p = hv_dac_sclk; m_sync_p = hv_dac_sync_b; m_load_p = hv_dac_load_b;
      end
   end

   task automatic clear_mon();
      q_chip.delete(); q_word.delete(); q_bits.delete(); q_len.delete();
      q_tfall.delete(); q_tlfall.delete(); q_llen.delete();
      fd_cnt = 0; viol = 0;
   endtask

   task automatic wr(input logic [1:0] c, input logic [23:0] w);
      wr_en = 1'b1; wr_chip = c; wr_word = w;
      @(negedge dtc_clk);
      wr_en = 1'b0;
   endtask

   // Waits until the block has been idle with nothing pending for 4 cycles.
   task automatic wait_quiet(input int budget, output bit ok);
      int q = 0, n = 0;
      while (q < 4 && n < budget) begin
         @(negedge dtc_clk);
         n++;
         if (!busy && pending == 4'h0) q++; else q = 0;
      end
      ok = (q >= 4);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge dtc_clk);
      n_cmp++; if (hv_dac_sync_b !== 4'hF) begin n_bad++; $display("FAIL rst_sync_b got %h want f", hv_dac_sync_b); end
      n_cmp++; if (hv_dac_sclk !== 1'b1) begin n_bad++; $display("FAIL rst_sclk got %b want 1", hv_dac_sclk); end
      n_cmp++; if (hv_dac_din !== 1'b0) begin n_bad++; $display("FAIL rst_din got %b want 0", hv_dac_din); end
      n_cmp++; if (hv_dac_load_b !== 1'b1) begin n_bad++; $display("FAIL rst_load_b got %b want 1", hv_dac_load_b); end
      n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL rst_pending got %h want 0", pending); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
      rst = 1'b0;
   endtask

   // Write issued in the very first clock after reset release.
   task automatic test_single();
      bit ok;
      auto_ldac = 1'b1;
      clear_mon();
      wr(2'd1, 24'h330A5C);
      n_cmp++; if (pending !== 4'b0010) begin n_bad++; $display("FAIL single_pending got %b want 0010", pending); end
      wait_quiet(800, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout got busy want idle"); end
      n_cmp++; if (q_chip.size() != 1) begin n_bad++; $display("FAIL single_nframes got %0d want 1", q_chip.size()); end
      if (q_chip.size() == 1) begin
         n_cmp++; if (q_chip[0] != 1) begin n_bad++; $display("FAIL single_chip got %0d want 1", q_chip[0]); end
         n_cmp++; if (q_word[0] !== 24'h330A5C) begin n_bad++; $display("FAIL single_word got %h want 330a5c", q_word[0]); end
         n_cmp++; if (q_bits[0] != 24) begin n_bad++; $display("FAIL single_bits got %0d want 24", q_bits[0]); end
         // sync covers SETUP+SHIFT (49*4); GAP follows with sync high.
         n_cmp++; if (q_len[0] != 196) begin n_bad++; $display("FAIL single_sync_len got %0d want 196", q_len[0]); end
      end
      n_cmp++; if (q_llen.size() != 1) begin n_bad++; $display("FAIL single_nloads got %0d want 1", q_llen.size()); end
      if (q_llen.size() == 1 && q_tfall.size() == 1) begin
         n_cmp++; if (q_llen[0] != 8) begin n_bad++; $display("FAIL single_load_len got %0d want 8", q_llen[0]); end
         n_cmp++; if (q_tlfall[0] - q_tfall[0] != 200) begin n_bad++; $display("FAIL single_frame_to_load got %0d want 200", q_tlfall[0] - q_tfall[0]); end
      end
      n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL single_frame_done got %0d want 1", fd_cnt); end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL single_overlap got %0d want 0", viol); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int exp_chip[3] = '{0, 2, 3};
      logic [23:0] exp_word[3] = '{24'hA00001, 24'hB00002, 24'hC00003};
      rst = 1'b1; @(negedge dtc_clk); rst = 1'b0;
      clear_mon();
      auto_ldac = 1'b1;
      wr(2'd0, 24'hA00001); wr(2'd2, 24'hB00002); wr(2'd3, 24'hC00003);
      wait_quiet(2500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout got busy want idle"); end
      n_cmp++; if (q_chip.size() != 3) begin n_bad++; $display("FAIL b2b_nframes got %0d want 3", q_chip.size()); end
      if (q_chip.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (q_chip[i] != exp_chip[i]) begin n_bad++; $display("FAIL b2b_chip%0d got %0d want %0d", i, q_chip[i], exp_chip[i]); end
            n_cmp++; if (q_word[i] !== exp_word[i]) begin n_bad++; $display("FAIL b2b_word%0d got %h want %h", i, q_word[i], exp_word[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++; if (q_tfall[i] - q_tfall[i-1] != 200) begin n_bad++; $display("FAIL b2b_spacing%0d got %0d want 200", i, q_tfall[i] - q_tfall[i-1]); end
         end
      end
      n_cmp++; if (q_llen.size() != 1) begin n_bad++; $display("FAIL b2b_nloads got %0d want 1", q_llen.size()); end
      if (q_llen.size() == 1 && q_tfall.size() == 3) begin
         n_cmp++; if (q_tlfall[0] - q_tfall[2] != 200) begin n_bad++; $display("FAIL b2b_load_pos got %0d want 200", q_tlfall[0] - q_tfall[2]); end
      end
      n_cmp++; if (fd_cnt != 3) begin n_bad++; $display("FAIL b2b_frame_done got %0d want 3", fd_cnt); end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL b2b_overlap got %0d want 0", viol); end
   endtask

   // Two chip-2 writes land while chip 1 is framing; only the newer one is sent.
   task automatic test_overwrite();
      bit ok;
      auto_ldac = 1'b0;
      clear_mon();
      wr(2'd1, 24'h5A5A5A);
      repeat (20) @(negedge dtc_clk);
      wr(2'd2, 24'h111111); wr(2'd2, 24'h222222);
      wait_quiet(1500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovw_timeout got busy want idle"); end
      n_cmp++; if (q_chip.size() != 2) begin n_bad++; $display("FAIL ovw_nframes got %0d want 2", q_chip.size()); end
      if (q_chip.size() == 2) begin
         n_cmp++; if (q_word[0] !== 24'h5A5A5A) begin n_bad++; $display("FAIL ovw_word0 got %h want 5a5a5a", q_word[0]); end
         n_cmp++; if (q_chip[1] != 2) begin n_bad++; $display("FAIL ovw_chip1 got %0d want 2", q_chip[1]); end
         n_cmp++; if (q_word[1] !== 24'h222222) begin n_bad++; $display("FAIL ovw_word1 got %h want 222222", q_word[1]); end
      end
      n_cmp++; if (q_llen.size() != 0) begin n_bad++; $display("FAIL ovw_nloads got %0d want 0", q_llen.size()); end
   endtask

   task automatic test_write_during_shift();
      bit ok;
      auto_ldac = 1'b1;
      clear_mon();
      wr(2'd2, 24'hABCDEF);
      repeat (60) @(negedge dtc_clk);
      n_cmp++; if (hv_dac_sync_b !== 4'b1011) begin n_bad++; $display("FAIL wds_in_frame got %b want 1011", hv_dac_sync_b); end
      wr(2'd2, 24'h123456);
      n_cmp++; if (pending !== 4'b0100) begin n_bad++; $display("FAIL wds_pending got %b want 0100", pending); end
      wait_quiet(1500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wds_timeout got busy want idle"); end
      n_cmp++; if (q_chip.size() != 2) begin n_bad++; $display("FAIL wds_nframes got %0d want 2", q_chip.size()); end
      if (q_chip.size() == 2) begin
         n_cmp++; if (q_word[0] !== 24'hABCDEF) begin n_bad++; $display("FAIL wds_word0 got %h want abcdef", q_word[0]); end
         n_cmp++; if (q_word[1] !== 24'h123456) begin n_bad++; $display("FAIL wds_word1 got %h want 123456", q_word[1]); end
         n_cmp++; if (q_chip[1] != 2) begin n_bad++; $display("FAIL wds_chip1 got %0d want 2", q_chip[1]); end
         n_cmp++; if (q_tfall[1] - q_tfall[0] != 200) begin n_bad++; $display("FAIL wds_spacing got %0d want 200", q_tfall[1] - q_tfall[0]); end
      end
      n_cmp++; if (q_llen.size() != 1) begin n_bad++; $display("FAIL wds_nloads got %0d want 1", q_llen.size()); end
   endtask

   // Manual load requested mid-frame: issued one IDLE cycle after GAP ends.
   task automatic test_manual_ldac();
      bit ok;
      auto_ldac = 1'b0;
      clear_mon();
      wr(2'd3, 24'h0F0F0F);
      repeat (100) @(negedge dtc_clk);
      ldac_req = 1'b1; @(negedge dtc_clk); ldac_req = 1'b0;
      n_cmp++; if (hv_dac_load_b !== 1'b1) begin n_bad++; $display("FAIL man_load_early got %b want 1", hv_dac_load_b); end
      wait_quiet(1500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL man_timeout got busy want idle"); end
      n_cmp++; if (q_chip.size() != 1) begin n_bad++; $display("FAIL man_nframes got %0d want 1", q_chip.size()); end
      n_cmp++; if (q_llen.size() != 1) begin n_bad++; $display("FAIL man_nloads got %0d want 1", q_llen.size()); end
      if (q_llen.size() == 1 && q_tfall.size() == 1) begin
         n_cmp++; if (q_llen[0] != 8) begin n_bad++; $display("FAIL man_load_len got %0d want 8", q_llen[0]); end
         n_cmp++; if (q_tlfall[0] - q_tfall[0] != 201) begin n_bad++; $display("FAIL man_load_pos got %0d want 201", q_tlfall[0] - q_tfall[0]); end
      end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL man_overlap got %0d want 0", viol); end
   endtask

   task automatic test_reset_midframe();
      int bad = 0;
      auto_ldac = 1'b1;
      wr(2'd0, 24'hC3C3C3);
      repeat (110) @(negedge dtc_clk);
      n_cmp++; if (hv_dac_sync_b !== 4'b1110) begin n_bad++; $display("FAIL rmf_in_frame got %b want 1110", hv_dac_sync_b); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (hv_dac_sync_b !== 4'hF) begin n_bad++; $display("FAIL rmf_sync_b got %h want f", hv_dac_sync_b); end
      n_cmp++; if (hv_dac_sclk !== 1'b1) begin n_bad++; $display("FAIL rmf_sclk got %b want 1", hv_dac_sclk); end
      n_cmp++; if (hv_dac_din !== 1'b0) begin n_bad++; $display("FAIL rmf_din got %b want 0", hv_dac_din); end
      n_cmp++; if (hv_dac_load_b !== 1'b1) begin n_bad++; $display("FAIL rmf_load_b got %b want 1", hv_dac_load_b); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmf_busy got %b want 0", busy); end
      @(negedge dtc_clk);
      rst = 1'b0;
      repeat (300) begin
         @(negedge dtc_clk);
         if (hv_dac_sync_b !== 4'hF || hv_dac_load_b !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rmf_quiet_after got %0d active cycles want 0", bad); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overwrite();
      test_write_during_shift();
      test_manual_ldac();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
